// File: rtl/mm_burst_reader.sv
// Burst read master for the dual-port memory: reads len consecutive words from a
// base address and streams them out through a 2-entry registered buffer.
module mm_burst_reader #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              rd_clk,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int LEN_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_clamped;
  logic [ADDR_W-1:0] next_addr;
  logic              rd_pending;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              pop;
  logic              accept;
  logic              room;
  logic              drained;
  logic [2:0]        demand;

  // A read is only issued if its word is guaranteed a buffer slot when it
  // returns, counting the beat leaving this cycle as already freed.
  always_comb begin
    pop         = valid_o & ready_i;
    accept      = start_i & ((state == S_IDLE) | (state == S_DONE));
    len_clamped = (len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_i;
    next_addr   = (rd_addr_o == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr_o + 1'b1;
    demand      = 3'(valid_o) + 3'(skid_valid) + 3'(rd_pending) + 3'd1;
    room        = pop ? (demand <= 3'd3) : (demand <= 3'd2);
    rd_en_o     = (state == S_READ) && (remaining != '0) && room;
    drained     = !rd_pending && !skid_valid && (!valid_o || pop);
    busy_o      = (state == S_READ) || (state == S_DRAIN);
    done_o      = (state == S_DONE);
  end

  // DONE also accepts a start so back-to-back commands lose no cycle.
  always_ff @(posedge rd_clk) begin
    if (rst_i) begin
      state     <= S_IDLE;
      remaining <= '0;
      rd_addr_o <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            rd_addr_o <= base_addr_i;
            remaining <= len_clamped;
            state     <= (len_clamped == '0) ? S_DONE : S_READ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_READ: begin
          if (rd_en_o) begin
            remaining <= remaining - 1'b1;
            rd_addr_o <= next_addr;
            if (remaining == LEN_W'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drained) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // data_o/valid_o is the buffer head; skid_data holds the second word when the
  // consumer stalls while a read is still returning.
  always_ff @(posedge rd_clk) begin
    if (rst_i) begin
      rd_pending <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
    end else begin
      rd_pending <= rd_en_o;
      if (!valid_o || pop) begin
        if (skid_valid) begin
          data_o     <= skid_data;
          valid_o    <= 1'b1;
          skid_valid <= rd_pending;
          if (rd_pending) skid_data <= mem_data_i;
        end else if (rd_pending) begin
          data_o  <= mem_data_i;
          valid_o <= 1'b1;
        end else begin
          valid_o <= 1'b0;
        end
      end else if (rd_pending) begin
        skid_data  <= mem_data_i;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mm_burst_reader.sv
// Scoreboard bench for mm_burst_reader: directed commands push expected words and
// addresses; a negedge monitor pops and compares every read and every beat.
module tb_mm_burst_reader;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic              rd_clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W:0]   len_i;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              busy_o;
  logic              done_o;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];

  int compared   = 0;
  int mismatched = 0;
  int beats      = 0;
  int dones      = 0;
  int issues     = 0;
  int xfers      = 0;

  mm_burst_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .rd_clk      (rd_clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .mem_data_i  (mem_data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 rd_clk = ~rd_clk;

  // Memory read port with one cycle of latency.
  always @(posedge rd_clk) begin
    if (rd_en_o) mem_data_i <= mem[rd_addr_o];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    int n;
    n = (int'(len) > DEPTH) ? DEPTH : int'(len);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[(int'(base) + i) % DEPTH]);
      addr_q.push_back(ADDR_W'((int'(base) + i) % DEPTH));
    end
    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = len;
    @(posedge rd_clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic runUntilDone(input string name, input int budget, input bit stall);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      ready_i = stall ? (c % 3 == 0) : 1'b1;
      @(negedge rd_clk);
      if (done_o) seen = 1'b1;
      @(posedge rd_clk);
      #1;
    end
    ready_i = 1'b1;
    checkOutput({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_rd_en"}, int'(rd_en_o), 0);
    checkOutput({name, "_valid"}, int'(valid_o), 0);
    checkOutput({name, "_busy"},  int'(busy_o), 0);
    checkOutput({name, "_done"},  int'(done_o), 0);
    checkOutput({name, "_data"},  int'(data_o), 0);
  endtask

  // Monitor: the values seen at a negedge are what the next rising edge acts on.
  initial begin
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    forever begin
      @(negedge rd_clk);
      if (rst_i) begin
        exp_q.delete();
        addr_q.delete();
        prev_stall = 1'b0;
        issues     = 0;
        xfers      = 0;
      end else begin
        if (prev_stall) begin
          checkOutput("hold_valid", int'(valid_o), 1);
          checkOutput("hold_data", int'(data_o), int'(prev_data));
        end
        if (rd_en_o) begin
          checkOutput("read_expected", int'(addr_q.size() != 0), 1);
          if (addr_q.size() != 0) checkOutput("rd_addr", int'(rd_addr_o), int'(addr_q.pop_front()));
        end
        if (valid_o && ready_i) begin
          checkOutput("beat_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) checkOutput("beat_data", int'(data_o), int'(exp_q.pop_front()));
          beats++;
        end
        if (valid_o || rd_en_o) begin
          compared++;
          if (issues - xfers > 2) begin
            mismatched++;
            $display("[TB] FAIL inflight: got %0d words held, expected at most 2", issues - xfers);
          end
        end
        issues += int'(rd_en_o);
        xfers  += int'(valid_o && ready_i);
        if (done_o) dones++;
        prev_stall = valid_o && !ready_i;
        prev_data  = data_o;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    int d0;
    int b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
    rst_i       = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    len_i       = '0;
    ready_i     = 1'b1;

    $display("[TB] reset");
    repeat (2) @(posedge rd_clk);
    #1;
    checkAllZero("t1");
    rst_i = 1'b0;
    idleCycles(2);

    $display("[TB] full burst, ready high");
    d0 = dones;
    applyStimulus(3'd0, 4'd8);
    @(negedge rd_clk);
    checkOutput("t2_rd_en_e0", int'(rd_en_o), 1);
    checkOutput("t2_busy_e0", int'(busy_o), 1);
    checkOutput("t2_valid_e0", int'(valid_o), 0);
    @(negedge rd_clk);
    checkOutput("t2_valid_e1", int'(valid_o), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      checkOutput("t2_valid_run", int'(valid_o), 1);
    end
    @(negedge rd_clk);
    checkOutput("t2_done_pulse", int'(done_o), 1);
    checkOutput("t2_valid_after", int'(valid_o), 0);
    @(negedge rd_clk);
    checkOutput("t2_done_clear", int'(done_o), 0);
    checkOutput("t2_busy_clear", int'(busy_o), 0);
    idleCycles(2);
    checkOutput("t2_left_over", exp_q.size(), 0);
    checkOutput("t2_done_count", dones - d0, 1);

    $display("[TB] wrapping burst");
    d0 = dones;
    applyStimulus(3'd6, 4'd4);
    runUntilDone("t3", 20, 1'b0);
    idleCycles(3);
    checkOutput("t3_left_over", exp_q.size(), 0);
    checkOutput("t3_addr_left", addr_q.size(), 0);
    checkOutput("t3_done_count", dones - d0, 1);

    $display("[TB] backpressure");
    d0 = dones;
    b0 = beats;
    applyStimulus(3'd0, 4'd8);
    runUntilDone("t4", 80, 1'b1);
    idleCycles(3);
    checkOutput("t4_beats", beats - b0, 8);
    checkOutput("t4_left_over", exp_q.size(), 0);
    checkOutput("t4_done_count", dones - d0, 1);

    $display("[TB] zero and oversized length");
    d0 = dones;
    applyStimulus(3'd0, 4'd0);
    @(negedge rd_clk);
    checkOutput("t5_len0_done", int'(done_o), 1);
    checkOutput("t5_len0_rd_en", int'(rd_en_o), 0);
    checkOutput("t5_len0_busy", int'(busy_o), 0);
    @(negedge rd_clk);
    checkOutput("t5_len0_done_clear", int'(done_o), 0);
    checkOutput("t5_len0_valid", int'(valid_o), 0);
    idleCycles(2);
    checkOutput("t5_len0_done_count", dones - d0, 1);
    d0 = dones;
    b0 = beats;
    applyStimulus(3'd0, 4'd12);
    runUntilDone("t5", 30, 1'b0);
    idleCycles(3);
    checkOutput("t5_len12_beats", beats - b0, 8);
    checkOutput("t5_len12_done_count", dones - d0, 1);

    $display("[TB] reset mid-burst, then ignored start while busy");
    d0 = dones;
    applyStimulus(3'd0, 4'd8);
    repeat (4) @(posedge rd_clk);
    #1;
    rst_i = 1'b1;
    @(posedge rd_clk);
    #1;
    rst_i = 1'b0;
    checkAllZero("t6_rst");
    idleCycles(4);
    checkOutput("t6_no_done", dones - d0, 0);
    d0 = dones;
    b0 = beats;
    applyStimulus(3'd0, 4'd2);
    start_i     = 1'b1;
    base_addr_i = 3'd5;
    len_i       = 4'd3;
    @(posedge rd_clk);
    #1;
    start_i = 1'b0;
    runUntilDone("t6", 20, 1'b0);
    idleCycles(6);
    checkOutput("t6_beats", beats - b0, 2);
    checkOutput("t6_done_count", dones - d0, 1);
    checkOutput("t6_left_over", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
